// File: rtl/dcache_controller.sv
// Data-cache controller for the MEM stage.
// The cache is 2-way set-associative with 64 sets of 8-byte blocks and one LRU bit per set.
// Writes go through to the SRAM controller and a write miss does not allocate a line.
// A read hit completes in the same cycle. A read miss or any write holds ready low
// until the SRAM controller pulses sram_ready.
module dcache_controller #(
   parameter logic [31:0] ADDR_BASE = 32'd1024,
   parameter int unsigned SETS      = 64,
   parameter int unsigned TAG_W     = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        sram_req,
   output logic        sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [63:0] sram_rdata,
   input  logic        sram_ready
);

   localparam int unsigned IdxW = $clog2(SETS);

   typedef enum logic [1:0] {
      StIdle,
      StRmiss,
      StWrite
   } state_e;

   state_e state_q;

   // Per-way storage. Only the valid and lru bits are reset.
   logic [SETS-1:0]  valid0_q, valid1_q, lru_q;
   logic [TAG_W-1:0] tag0_q  [SETS];
   logic [TAG_W-1:0] tag1_q  [SETS];
   logic [63:0]      data0_q [SETS];
   logic [63:0]      data1_q [SETS];

   // Address decode relative to the data-memory base
   logic [31:0]      offset;
   logic             word_sel;
   logic [IdxW-1:0]  idx;
   logic [TAG_W-1:0] tag;
   logic             unused_offset;

   assign offset        = address - ADDR_BASE;
   assign word_sel      = offset[2];
   assign idx           = offset[3 +: IdxW];
   assign tag           = offset[3+IdxW +: TAG_W];
   assign unused_offset = ^{offset[1:0], offset[31:3+IdxW+TAG_W]};

   // Lookup
   logic        hit0, hit1, hit, hit_way;
   logic [63:0] hit_blk;
   logic [31:0] hit_word;
   logic        victim;

   assign hit0     = valid0_q[idx] && (tag0_q[idx] == tag);
   assign hit1     = valid1_q[idx] && (tag1_q[idx] == tag);
   assign hit      = hit0 | hit1;
   assign hit_way  = hit1;
   assign hit_blk  = hit1 ? data1_q[idx] : data0_q[idx];
   assign hit_word = word_sel ? hit_blk[63:32] : hit_blk[31:0];

   // The fill goes to an invalid way first (way0 before way1). Otherwise it goes to the LRU way.
   assign victim = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);

   logic touch_en;  // read hit: refresh lru
   logic fill_en;   // read miss completing: allocate block
   logic upd_en;    // write hit completing: patch one word

   // Outputs and update strobes. These are decoded from the state and inputs. Reset forces idle.
   always_comb begin
      ready      = 1'b1;
      rdata      = 32'd0;
      sram_req   = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = 32'd0;
      sram_wdata = 32'd0;
      touch_en   = 1'b0;
      fill_en    = 1'b0;
      upd_en     = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StIdle: begin
               if (wr_en) begin
                  ready = 1'b0;
               end else if (rd_en) begin
                  if (hit) begin
                     rdata    = hit_word;
                     touch_en = 1'b1;
                  end else begin
                     ready = 1'b0;
                  end
               end
            end
            StRmiss: begin
               sram_req  = 1'b1;
               sram_addr = {address[31:3], 3'b000};
               ready     = sram_ready;
               if (sram_ready) begin
                  rdata   = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                  fill_en = 1'b1;
               end
            end
            StWrite: begin
               sram_req   = 1'b1;
               sram_we    = 1'b1;
               sram_addr  = {address[31:2], 2'b00};
               sram_wdata = wdata;
               ready      = sram_ready;
               upd_en     = sram_ready & hit;
            end
            default: ;
         endcase
      end
   end

   // FSM, valid bits and LRU bits. A write takes priority over a simultaneous read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         valid0_q <= '0;
         valid1_q <= '0;
         lru_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (wr_en) begin
                  state_q <= StWrite;
               end else if (rd_en && !hit) begin
                  state_q <= StRmiss;
               end
            end
            StRmiss, StWrite: begin
               if (sram_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         if (touch_en || upd_en) begin
            lru_q[idx] <= ~hit_way;
         end
         if (fill_en) begin
            if (victim) begin
               valid1_q[idx] <= 1'b1;
            end else begin
               valid0_q[idx] <= 1'b1;
            end
            lru_q[idx] <= ~victim;
         end
      end
   end

   // Tag and data arrays. These have no reset and are only meaningful where valid is set.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         if (victim) begin
            tag1_q[idx]  <= tag;
            data1_q[idx] <= sram_rdata;
         end else begin
            tag0_q[idx]  <= tag;
            data0_q[idx] <= sram_rdata;
         end
      end
      if (upd_en) begin
         if (hit_way) begin
            if (word_sel) data1_q[idx][63:32] <= wdata;
            else          data1_q[idx][31:0]  <= wdata;
         end else begin
            if (word_sel) data0_q[idx][63:32] <= wdata;
            else          data0_q[idx][31:0]  <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller.
// The bench drives inputs on the falling edge and samples outputs 1ns later.
module tb_dcache_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en, sram_ready;
   logic [31:0] address, wdata;
   logic [63:0] sram_rdata;
   logic [31:0] rdata, sram_addr, sram_wdata;
   logic        ready, sram_req, sram_we;

   int checks = 0;
   int errors = 0;

   dcache_controller dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .wr_en      (wr_en),
      .address    (address),
      .wdata      (wdata),
      .rdata      (rdata),
      .ready      (ready),
      .sram_req   (sram_req),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .sram_ready (sram_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; sram_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Full read-miss transaction: lat wait cycles before sram_ready
   task automatic read_miss(input logic [31:0] a, input logic [63:0] blk, input int lat);
      logic [31:0] w;
      w = a[2] ? blk[63:32] : blk[31:0];
      @(negedge clk);
      rd_en = 1'b1; wr_en = 1'b0; address = a;
      #1 chk1("rmiss_idle_ready", ready, 1'b0);
      chk1("rmiss_idle_req", sram_req, 1'b0);
      @(negedge clk);
      #1 chk1("rmiss_req", sram_req, 1'b1);
      chk1("rmiss_we", sram_we, 1'b0);
      chk32("rmiss_addr", sram_addr, {a[31:3], 3'b000});
      chk1("rmiss_ready", ready, 1'b0);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         #1 chk1("rmiss_wait_ready", ready, 1'b0);
      end
      @(negedge clk);
      sram_ready = 1'b1; sram_rdata = blk;
      #1 chk1("rmiss_done_ready", ready, 1'b1);
      chk32("rmiss_done_rdata", rdata, w);
      @(negedge clk);
      sram_ready = 1'b0; rd_en = 1'b0;
      #1 chk1("rmiss_after_req", sram_req, 1'b0);
      chk1("rmiss_after_ready", ready, 1'b1);
   endtask

   task automatic read_hit(input logic [31:0] a, input logic [31:0] w);
      @(negedge clk);
      rd_en = 1'b1; wr_en = 1'b0; address = a;
      #1 chk1("hit_ready", ready, 1'b1);
      chk32("hit_rdata", rdata, w);
      chk1("hit_req", sram_req, 1'b0);
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic also_rd,
                            input int lat);
      @(negedge clk);
      wr_en = 1'b1; rd_en = also_rd; address = a; wdata = d;
      #1 chk1("wr_idle_ready", ready, 1'b0);
      @(negedge clk);
      #1 chk1("wr_req", sram_req, 1'b1);
      chk1("wr_we", sram_we, 1'b1);
      chk32("wr_addr", sram_addr, {a[31:2], 2'b00});
      chk32("wr_wdata", sram_wdata, d);
      chk1("wr_ready", ready, 1'b0);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         #1 chk1("wr_wait_ready", ready, 1'b0);
      end
      @(negedge clk);
      sram_ready = 1'b1; sram_rdata = 64'd0;
      #1 chk1("wr_done_ready", ready, 1'b1);
      @(negedge clk);
      sram_ready = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      #1 chk1("wr_after_req", sram_req, 1'b0);
   endtask

   initial begin
      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; sram_ready = 1'b0;
      address = 32'd0; wdata = 32'd0; sram_rdata = 64'd0;
      #1;
      chk1("rst_ready", ready, 1'b1);
      chk1("rst_req", sram_req, 1'b0);
      chk1("rst_we", sram_we, 1'b0);
      chk32("rst_addr", sram_addr, 32'd0);
      chk32("rst_wdata", sram_wdata, 32'd0);
      chk32("rst_rdata", rdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Cold miss, then a neighbour word hits
      read_miss(32'h400, 64'h00000002_00000001, 4);
      read_hit(32'h404, 32'h2);

      // Write hit patches only the selected word
      write_txn(32'h400, 32'hDEADBEEF, 1'b0, 2);
      read_hit(32'h400, 32'hDEADBEEF);
      read_hit(32'h404, 32'h2);

      // Write miss does not allocate
      write_txn(32'h800, 32'h12345678, 1'b0, 1);
      read_miss(32'h800, 64'h0000BBBB_0000AAAA, 0);

      // LRU on set 0: A, B fill, A touched, C evicts B
      do_reset();
      read_miss(32'h400, 64'h000000A1_000000A0, 1);
      read_miss(32'h600, 64'h000000B1_000000B0, 1);
      read_hit(32'h400, 32'hA0);
      read_miss(32'h800, 64'h000000C1_000000C0, 1);
      read_hit(32'h400, 32'hA0);
      read_miss(32'h600, 64'h000000B1_000000B0, 0);
      read_hit(32'h400, 32'hA0);

      // Reset in the middle of a miss. A sram_ready pulse during reset must not fill the line.
      do_reset();
      @(negedge clk);
      rd_en = 1'b1; address = 32'h400;
      #1 chk1("mid_idle_ready", ready, 1'b0);
      @(negedge clk);
      #1 chk1("mid_req", sram_req, 1'b1);
      @(negedge clk);
      rst = 1'b1; sram_ready = 1'b1; sram_rdata = 64'h99999999_88888888;
      #1 chk1("mid_rst_req", sram_req, 1'b0);
      chk1("mid_rst_ready", ready, 1'b1);
      chk32("mid_rst_rdata", rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0; sram_ready = 1'b0;
      #1 chk1("mid_rel_ready", ready, 1'b0);
      @(negedge clk);
      #1 chk1("mid_rel_req", sram_req, 1'b1);
      chk32("mid_rel_addr", sram_addr, 32'h400);
      @(negedge clk);
      sram_ready = 1'b1; sram_rdata = 64'h22222222_11111111;
      #1 chk1("mid_done_ready", ready, 1'b1);
      chk32("mid_done_rdata", rdata, 32'h11111111);
      @(negedge clk);
      sram_ready = 1'b0; rd_en = 1'b0;

      // Stray sram_ready in idle has no effect
      @(negedge clk);
      sram_ready = 1'b1; sram_rdata = 64'hFFFFFFFF_FFFFFFFF;
      #1 chk1("stray_ready", ready, 1'b1);
      chk1("stray_req", sram_req, 1'b0);
      @(negedge clk);
      sram_ready = 1'b0;
      #1 chk1("stray_after_req", sram_req, 1'b0);
      read_hit(32'h400, 32'h11111111);

      // Read and write together: the write wins and the read is dropped
      write_txn(32'h408, 32'hCAFEF00D, 1'b1, 1);
      read_miss(32'h408, 64'h00000004_00000003, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Data-cache controller in the MEM stage. It answers MEM_R_EN/MEM_W_EN accesses from the pipeline and produces the ready signal; the pipeline freezes IF/ID on ~ready.
- Organisation: 2-way set-associative, 64 sets, 8-byte (two-word) blocks, one LRU bit per set.
- Write policy: write-through, no write-allocate.
- Backing store: the SRAM controller, reached over a req/ready handshake.

Parameters:
ADDR_BASE, 32'd1024, data-memory base; offset = address - ADDR_BASE.
SETS, 64, number of sets (index width log2(SETS) = 6).
TAG_W, 10, tag width; tag = offset[18:9].

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
rd_en  in  1  read request (MEM_R_EN).
wr_en  in  1  write request (MEM_W_EN).
address  in  32  byte address from ALU result.
wdata  in  32  store data (rm value).
rdata  out  32  load data; valid when ready=1 and a read is active.
ready  out  1  access complete or no access; pipeline freeze = ~ready.
sram_req  out  1  SRAM request, held until sram_ready.
sram_we  out  1  1 = write, 0 = 64-bit block read.
sram_addr  out  32  SRAM byte address.
sram_wdata  out  32  SRAM write data.
sram_rdata  in  64  block data; [31:0] = even word, [63:32] = odd word.
sram_ready  in  1  one-cycle completion pulse.

Behaviour:
- Address fields
  - offset = address - ADDR_BASE; word select = offset[2]; index = offset[8:3]; tag = offset[18:9].
- Storage
  - Per set, per way: valid, tag[9:0], data[63:0].
  - Per set: lru bit. lru=0 means way0 is least recently used.
  - hit = valid & tag match in either way, evaluated combinationally.
- Reset (async)
  - All valid bits and lru bits cleared.
  - State = IDLE; sram_req=0, sram_we=0, sram_addr=0, sram_wdata=0, rdata=0, ready=1.
- Request priority
  - wr_en has priority over rd_en; if both are high, the access is a write and the read is ignored.
- Requester contract
  - Hold address, wdata, rd_en and wr_en stable while ready=0.
  - Change or drop the request in the cycle after ready=1.
- State IDLE
  - No request: ready=1, rdata=0.
  - Read hit: ready=1 in the same cycle (zero latency); rdata = hit word. At the edge, lru[index] points to the other way.
  - Read miss: ready=0; go to RMISS.
  - Write (hit or miss): ready=0; go to WRITE.
- State RMISS
  - sram_req=1, sram_we=0, sram_addr = {address[31:3], 3'b000}.
  - Without sram_ready: ready=0 and the state holds.
  - On the sram_ready cycle: ready=1; rdata = sram_rdata word selected by offset[2].
  - At that edge, fill the victim way: way0 if invalid, else way1 if invalid, else the way named by lru. Set valid, tag and data; lru points away from the filled way; go to IDLE.
- State WRITE
  - sram_req=1, sram_we=1, sram_addr = {address[31:2], 2'b00}, sram_wdata = wdata.
  - On the sram_ready cycle: ready=1.
  - At that edge, if hit: replace the word selected by offset[2] in the hit way and update lru. On a miss the cache is unchanged (no allocate). Go to IDLE.
- sram_req
  - Registered-free: driven from state, so it asserts in the same cycle the state is RMISS/WRITE.
  - Deasserts in the cycle after sram_ready.
- Boundary cases
  - sram_ready in IDLE is ignored.
  - rd_en/wr_en dropping mid-miss is a requester-contract violation; the controller completes the SRAM transaction regardless.
  - Reset mid-RMISS/WRITE: sram_req drops immediately, no fill, no word update; IDLE after release.
  - Same-index thrash on three tags: LRU decides the victim; invalid ways are always filled first.

Test Plan:
- Cold read miss then neighbour hit
  - Stimulus: reset; rd_en, address=0x400.
  - Expected: ready=0, sram_req=1, sram_we=0, sram_addr=0x400.
  - Stimulus: sram_ready with sram_rdata=64'h00000002_00000001 after 4 cycles.
  - Expected: ready=1, rdata=0x1 that cycle.
  - Stimulus: read 0x404.
  - Expected: ready=1 same cycle, rdata=0x2, sram_req stays 0.
- Write hit
  - Stimulus: write 0x400, wdata=0xDEADBEEF.
  - Expected: sram_we=1, sram_addr=0x400, ready=0 until sram_ready.
  - Stimulus: read 0x400.
  - Expected: immediate hit, rdata=0xDEADBEEF.
- Write miss, no allocate
  - Stimulus: write 0x800, then read 0x800.
  - Expected: the read misses (sram_req=1, sram_we=0, sram_addr=0x800).
- LRU replacement (same index 0)
  - Stimulus: fill A=0x400 and B=0x600; read A (hit).
  - Stimulus: read C=0x800.
  - Expected: miss replaces B.
  - Stimulus: read A, then read B.
  - Expected: A hits; B misses.
- Reset mid-miss
  - Stimulus: read 0x400 miss; assert rst before sram_ready.
  - Expected: sram_req=0 and ready=1 immediately.
  - Stimulus: release rst; read 0x400.
  - Expected: miss again.
- Ignored inputs
  - Stimulus: sram_ready pulse in IDLE.
  - Expected: no state change.
  - Stimulus: rd_en=wr_en=1 at 0x408.
  - Expected: WRITE transaction (sram_we=1).
